// File: rtl/spaceship_laser.sv
// Player laser launcher: captures fire presses, flies one shot up the screen
// per video frame, retires it on a hit or at the top edge, then cools down.
module spaceship_laser #(
  parameter logic [10:0] LASER_START_Y   = 11'd440,
  parameter logic [10:0] LASER_PARK_X    = 11'd0,
  parameter logic [10:0] LASER_PARK_Y    = 11'd0,
  parameter logic [10:0] TOP_EDGE        = 11'd5,
  parameter logic [10:0] LASER_SPEED     = 11'd4,
  parameter logic [10:0] LASER_HEIGHT    = 11'd10,
  parameter logic [10:0] LASER_LENGTH    = 11'd3,
  parameter logic [7:0]  COOLDOWN_FRAMES = 8'd15,
  parameter logic [7:0]  COLOR_LASER     = 8'b00111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [10:0] xCoord,
  input  logic [10:0] yCoord,
  input  logic        fire,
  input  logic [10:0] spaceship_xCoord,
  input  logic        is_hit,
  output logic [10:0] spaceship_laser_xCoord,
  output logic [10:0] spaceship_laser_yCoord,
  output logic        laser_active,
  output logic        is_laser,
  output logic [7:0]  rgb,
  output logic [7:0]  shots_fired
);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

  localparam logic [10:0] HALF_L   = LASER_LENGTH / 11'd2;
  localparam logic [10:0] HALF_H   = LASER_HEIGHT / 11'd2;
  localparam logic [10:0] EXIT_Y   = TOP_EDGE + LASER_SPEED;

  state_t      state, state_n;
  logic [7:0]  cooldown;
  logic        fire_q, fire_pending;
  logic        clr, step, launch, retire;
  logic [10:0] x_lo, x_hi, y_lo, y_hi;

  // Menu modes hold the block in reset; mode 3 simply freezes it.
  assign clr  = rst || (mode < 2'd2);
  assign step = (xCoord == 11'd0) && (yCoord == 11'd0) && (mode == 2'd2);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    retire  = 1'b0;
    case (state)
      IDLE: if (step && fire_pending) begin
        launch  = 1'b1;
        state_n = FLYING;
      end
      FLYING: if (step && (is_hit || spaceship_laser_yCoord <= EXIT_Y)) begin
        retire  = 1'b1;
        state_n = COOLDOWN;
      end
      COOLDOWN: if (step && cooldown == 8'd0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      spaceship_laser_xCoord <= LASER_PARK_X;
      spaceship_laser_yCoord <= LASER_PARK_Y;
      cooldown               <= 8'd0;
      fire_q                 <= 1'b0;
      fire_pending           <= 1'b0;
      shots_fired            <= 8'd0;
    end else begin
      fire_q <= fire;
      // A press landing on the tick clock itself carries into the next frame.
      fire_pending <= (fire && !fire_q) || (fire_pending && !step);
      if (launch) begin
        spaceship_laser_xCoord <= spaceship_xCoord;
        spaceship_laser_yCoord <= LASER_START_Y;
        if (shots_fired != 8'hFF) shots_fired <= shots_fired + 8'd1;
      end else if (retire) begin
        spaceship_laser_xCoord <= LASER_PARK_X;
        spaceship_laser_yCoord <= LASER_PARK_Y;
        cooldown               <= COOLDOWN_FRAMES;
      end else if (step && state == FLYING) begin
        spaceship_laser_yCoord <= spaceship_laser_yCoord - LASER_SPEED;
      end
      if (step && state == COOLDOWN && cooldown != 8'd0)
        cooldown <= cooldown - 8'd1;
    end
  end

  // While flying y stays above TOP_EDGE, so the lower bounds cannot wrap.
  always_comb begin
    x_lo         = spaceship_laser_xCoord - HALF_L;
    x_hi         = spaceship_laser_xCoord + HALF_L;
    y_lo         = spaceship_laser_yCoord - HALF_H;
    y_hi         = spaceship_laser_yCoord + HALF_H;
    laser_active = (state == FLYING);
    is_laser     = laser_active &&
                   (x_lo <= xCoord) && (xCoord <= x_hi) &&
                   (y_lo <= yCoord) && (yCoord <= y_hi);
    rgb          = is_laser ? COLOR_LASER : 8'd0;
  end

endmodule

// File: tb/tb_spaceship_laser.sv
// Directed bench for spaceship_laser: launch, top exit, hit retire, cooldown,
// hold-without-repeat, mid-flight reset, pixel window and shot saturation.
`timescale 1ns/1ps
module tb_spaceship_laser;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [10:0] xCoord, yCoord;
  logic        fire;
  logic [10:0] spaceship_xCoord;
  logic        is_hit;
  logic [10:0] spaceship_laser_xCoord, spaceship_laser_yCoord;
  logic        laser_active, is_laser;
  logic [7:0]  rgb, shots_fired;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spaceship_laser dut (
    .clk                    (clk),
    .rst                    (rst),
    .mode                   (mode),
    .xCoord                 (xCoord),
    .yCoord                 (yCoord),
    .fire                   (fire),
    .spaceship_xCoord       (spaceship_xCoord),
    .is_hit                 (is_hit),
    .spaceship_laser_xCoord (spaceship_laser_xCoord),
    .spaceship_laser_yCoord (spaceship_laser_yCoord),
    .laser_active           (laser_active),
    .is_laser               (is_laser),
    .rgb                    (rgb),
    .shots_fired            (shots_fired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One frame: a single tick clock at (0,0), then one ordinary pixel clock.
  task automatic frame();
    xCoord = 11'd0; yCoord = 11'd0;
    @(posedge clk); #1;
    xCoord = 11'd1; yCoord = 11'd1;
    @(posedge clk); #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic press();
    fire = 1'b1;
    @(posedge clk); #1;
    fire = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pix(input string tag, input int px, input int py, input logic exp_in);
    xCoord = px[10:0]; yCoord = py[10:0];
    #1;
    check({tag, "_is_laser"}, is_laser, exp_in);
    check({tag, "_rgb"}, rgb, exp_in ? 32'h3F : 32'h0);
    xCoord = 11'd1; yCoord = 11'd1;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 2'd2; xCoord = 11'd1; yCoord = 11'd1;
    fire = 1'b0; spaceship_xCoord = 11'd320; is_hit = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;

    check("rst_x", spaceship_laser_xCoord, 0);
    check("rst_y", spaceship_laser_yCoord, 0);
    check("rst_active", laser_active, 0);
    check("rst_shots", shots_fired, 0);
    check("rst_rgb", rgb, 0);

    // Basic launch
    press(); frame();
    check("launch_x", spaceship_laser_xCoord, 320);
    check("launch_y", spaceship_laser_yCoord, 440);
    check("launch_active", laser_active, 1);
    check("launch_shots", shots_fired, 1);
    frame(); check("move1_y", spaceship_laser_yCoord, 436);
    frame(); check("move2_y", spaceship_laser_yCoord, 432);
    check("move2_x", spaceship_laser_xCoord, 320);

    // Top exit
    frames(105); check("y12", spaceship_laser_yCoord, 12);
    frame();     check("y8", spaceship_laser_yCoord, 8);
    check("y8_active", laser_active, 1);
    frame();
    check("exit_x", spaceship_laser_xCoord, 0);
    check("exit_y", spaceship_laser_yCoord, 0);
    check("exit_active", laser_active, 0);

    // Cooldown: press before 16th tick is dropped, before 17th launches
    frames(15); press(); frame();
    check("cd_drop_active", laser_active, 0);
    check("cd_drop_shots", shots_fired, 1);
    press(); frame();
    check("cd_relaunch_active", laser_active, 1);
    check("cd_relaunch_shots", shots_fired, 2);

    // Hit retire at y=200
    frames(60); check("hit_pre_y", spaceship_laser_yCoord, 200);
    is_hit = 1'b1; frame();
    check("hit_active", laser_active, 0);
    check("hit_x", spaceship_laser_xCoord, 0);
    check("hit_y", spaceship_laser_yCoord, 0);
    // is_hit held through cooldown and into IDLE has no effect
    frames(15); press(); frame();
    check("hit_cd_active", laser_active, 0);
    press(); frame();
    check("idle_hit_launch", laser_active, 1);
    check("idle_hit_y", spaceship_laser_yCoord, 440);
    check("idle_hit_shots", shots_fired, 3);
    is_hit = 1'b0;

    // Reset mid-flight via menu mode
    frames(35); check("mid_y", spaceship_laser_yCoord, 300);
    mode = 2'd1; @(posedge clk); #1; mode = 2'd2;
    check("mrst_active", laser_active, 0);
    check("mrst_x", spaceship_laser_xCoord, 0);
    check("mrst_y", spaceship_laser_yCoord, 0);
    check("mrst_shots", shots_fired, 0);
    pix("mrst_pix", 320, 300, 1'b0);
    frames(3);
    check("mrst_nolaunch", laser_active, 0);
    check("mrst_nolaunch_shots", shots_fired, 0);

    // Pixel window at (320,200)
    press(); frame();
    check("pw_shots", shots_fired, 1);
    frames(60); check("pw_y", spaceship_laser_yCoord, 200);
    pix("pw_c",  320, 200, 1'b1);
    pix("pw_ll", 319, 195, 1'b1);
    pix("pw_ur", 321, 205, 1'b1);
    pix("pw_xl", 318, 200, 1'b0);
    pix("pw_xr", 322, 200, 1'b0);
    pix("pw_yt", 320, 194, 1'b0);
    pix("pw_yb", 320, 206, 1'b0);
    is_hit = 1'b1; frame(); is_hit = 1'b0;
    pix("pw_inactive", 320, 200, 1'b0);
    frames(16);

    // Hold fire across 300 frames: exactly one launch
    fire = 1'b1;
    frames(300);
    check("hold_shots", shots_fired, 2);
    check("hold_active", laser_active, 0);
    fire = 1'b0; @(posedge clk); #1;
    press(); frame();
    check("repress_shots", shots_fired, 3);
    check("repress_active", laser_active, 1);

    // Saturation: 252 more launches reach 255, further ones hold it
    for (int i = 0; i < 260; i++) begin
      is_hit = 1'b1; frame(); is_hit = 1'b0;
      frames(16); press(); frame();
      if (i == 251) check("sat_reach", shots_fired, 255);
    end
    check("sat_hold", shots_fired, 255);
    check("sat_active", laser_active, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
